// File: rtl/idex_pkg.sv
// ============================================================================
//  Module   : idex_pkg
//  Purpose  : Shared operand-select codes and default widths for the ID/EX
//             pipeline register. Honours macro IDEX_FWD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package idex_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CTRL_W_DEF = 27;
   localparam int INSTR_W    = 32;
   localparam int ALUOP_W    = 5;
   localparam int REGDST_W   = 2;
   localparam int SEL_W      = 2;
   localparam int STALL_W    = 16;

   typedef enum logic [SEL_W-1:0] {
      SEL_RD        = 2'b00,
      SEL_EXT       = 2'b01,
      SEL_FWD_EXMEM = 2'b10,
      SEL_FWD_MEMWB = 2'b11
   } operand_sel_e;

   // Without forwarding hardware the forward codes collapse onto the
   // register-file read so every code still yields a defined operand.
   function automatic operand_sel_e eff_sel(input logic [SEL_W-1:0] raw);
`ifdef IDEX_FWD_EN
      return operand_sel_e'(raw);
`else
      return raw[1] ? SEL_RD : operand_sel_e'(raw);
`endif
   endfunction

endpackage

`default_nettype wire

// File: rtl/idex_operand_mux.sv
// ============================================================================
//  Module   : idex_operand_mux
//  Purpose  : 4:1 ALU operand selector (register read, immediate, forwards).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idex_operand_mux
   import idex_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [SEL_W-1:0]  sel,
   input  logic [DATA_W-1:0] rd_in,
   input  logic [DATA_W-1:0] ext_in,
   input  logic [DATA_W-1:0] fwd_exmem,
   input  logic [DATA_W-1:0] fwd_memwb,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = rd_in;
      case (sel)
         SEL_RD:        y = rd_in;
         SEL_EXT:       y = ext_in;
         SEL_FWD_EXMEM: y = fwd_exmem;
         SEL_FWD_MEMWB: y = fwd_memwb;
         default:       y = rd_in;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/idex_pipe_reg.sv
// ============================================================================
//  Module   : idex_pipe_reg
//  Purpose  : ID/EX valid/ready pipeline register with operand muxing, flush,
//             and a saturating stall counter. Macro IDEX_FWD_EN enables
//             forwarded operands on select codes 10/11.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idex_pipe_reg
   import idex_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int CTRL_W     = CTRL_W_DEF,
   parameter int ASEL_LSB   = 3,
   parameter int BSEL_LSB   = 1,
   parameter int ALUOP_LSB  = 14,
   parameter int REGDST_LSB = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CTRL_W-1:0]    ctrl_in,
   input  logic [DATA_W-1:0]    rd1_in,
   input  logic [DATA_W-1:0]    rd2_in,
   input  logic [DATA_W-1:0]    ext_in,
   input  logic [INSTR_W-1:0]   instr_in,
   input  logic [DATA_W-1:0]    fwd_exmem,
   input  logic [DATA_W-1:0]    fwd_memwb,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 flush,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    alu_a,
   output logic [DATA_W-1:0]    alu_b,
   output logic [DATA_W-1:0]    sw_rt,
   output logic [INSTR_W-1:0]   instr_out,
   output logic [CTRL_W-1:0]    ctrl_out,
   output logic                 out_valid,
   output logic [ALUOP_W-1:0]   alu_op,
   output logic [REGDST_W-1:0]  reg_dst,
   output logic [STALL_W-1:0]   stall_cnt
);

   logic                out_valid_q, out_valid_d;
   logic [CTRL_W-1:0]   ctrl_q,      ctrl_d;
   logic [INSTR_W-1:0]  instr_q,     instr_d;
   logic [DATA_W-1:0]   alu_a_q,     alu_a_d;
   logic [DATA_W-1:0]   alu_b_q,     alu_b_d;
   logic [DATA_W-1:0]   sw_rt_q,     sw_rt_d;
   logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic [DATA_W-1:0]   mux_a, mux_b;
   logic                load, stalled;

   idex_operand_mux #(.DATA_W(DATA_W)) u_mux_a (
      .sel       (eff_sel(ctrl_in[ASEL_LSB +: SEL_W])),
      .rd_in     (rd1_in),
      .ext_in    (ext_in),
      .fwd_exmem (fwd_exmem),
      .fwd_memwb (fwd_memwb),
      .y         (mux_a)
   );

   idex_operand_mux #(.DATA_W(DATA_W)) u_mux_b (
      .sel       (eff_sel(ctrl_in[BSEL_LSB +: SEL_W])),
      .rd_in     (rd2_in),
      .ext_in    (ext_in),
      .fwd_exmem (fwd_exmem),
      .fwd_memwb (fwd_memwb),
      .y         (mux_b)
   );

   assign in_ready = !out_valid_q || out_ready;
   assign load     = in_valid && in_ready && !flush;
   assign stalled  = out_valid_q && !out_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      ctrl_d      = ctrl_q;
      instr_d     = instr_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      sw_rt_d     = sw_rt_q;
      stall_cnt_d = stall_cnt_q;

      // Flush beats both load and stall; only valid and control are killed.
      if (flush) begin
         out_valid_d = 1'b0;
         ctrl_d      = '0;
      end else if (load) begin
         out_valid_d = 1'b1;
         ctrl_d      = ctrl_in;
         instr_d     = instr_in;
         alu_a_d     = mux_a;
         alu_b_d     = mux_b;
         sw_rt_d     = rd2_in;
      end else if (!stalled) begin
         out_valid_d = 1'b0;
      end

      if (stalled && (stall_cnt_q != {STALL_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(STALL_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         ctrl_q      <= '0;
         instr_q     <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         sw_rt_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         ctrl_q      <= ctrl_d;
         instr_q     <= instr_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         sw_rt_q     <= sw_rt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign ctrl_out  = ctrl_q;
   assign instr_out = instr_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign sw_rt     = sw_rt_q;
   assign stall_cnt = stall_cnt_q;
   assign alu_op    = ctrl_q[ALUOP_LSB +: ALUOP_W];
   assign reg_dst   = ctrl_q[REGDST_LSB +: REGDST_W];

endmodule

`default_nettype wire

// File: tb/tb_idex_pipe_reg.sv
// ============================================================================
//  Module   : tb_idex_pipe_reg
//  Purpose  : Self-checking bench for idex_pipe_reg (scoreboard + directed
//             scenarios). Follows macro IDEX_FWD_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idex_pipe_reg;

   localparam int DW = 32;
   localparam int CW = 27;
`ifdef IDEX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] ctrl_in;
   logic [DW-1:0] rd1_in, rd2_in, ext_in, fwd_exmem, fwd_memwb;
   logic [31:0]   instr_in;
   logic          in_valid, flush, out_ready;
   logic          in_ready, out_valid;
   logic [DW-1:0] alu_a, alu_b, sw_rt;
   logic [31:0]   instr_out;
   logic [CW-1:0] ctrl_out;
   logic [4:0]    alu_op;
   logic [1:0]    reg_dst;
   logic [15:0]   stall_cnt;

   idex_pipe_reg dut (
      .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .rd1_in(rd1_in), .rd2_in(rd2_in),
      .ext_in(ext_in), .instr_in(instr_in), .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb),
      .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .sw_rt(sw_rt), .instr_out(instr_out),
      .ctrl_out(ctrl_out), .out_valid(out_valid), .alu_op(alu_op), .reg_dst(reg_dst),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0] ctrl;
      logic [31:0]   instr;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] sw;
   } item_t;

   item_t       sb[$];
   logic        m_valid = 1'b0;
   logic [15:0] m_cnt   = 16'd0;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] pick(input logic [1:0] s, input logic [DW-1:0] rd,
                                          input logic [DW-1:0] e, input logic [DW-1:0] fe,
                                          input logic [DW-1:0] fm);
      if (s == 2'd1) return e;
      if (s == 2'd2) return FWD ? fe : rd;
      if (s == 2'd3) return FWD ? fm : rd;
      return rd;
   endfunction

   // Drive one cycle of stimulus, update the reference model, advance one edge.
   task automatic step(input logic iv, input logic fl, input logic ordy,
                       input logic [CW-1:0] c, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                       input logic [DW-1:0] e, input logic [DW-1:0] fe, input logic [DW-1:0] fm,
                       input logic [31:0] ins);
      item_t       it;
      logic        nv;
      logic [15:0] nc;
      in_valid = iv; flush = fl; out_ready = ordy; ctrl_in = c;
      rd1_in = r1; rd2_in = r2; ext_in = e; fwd_exmem = fe; fwd_memwb = fm; instr_in = ins;
      nc = (m_valid && !ordy && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
      if (fl) begin
         nv = 1'b0;
         if (m_valid && !ordy && sb.size() > 0) void'(sb.pop_front());
      end else if (iv && (!m_valid || ordy)) begin
         nv       = 1'b1;
         it.ctrl  = c;
         it.instr = ins;
         it.a     = pick(c[4:3], r1, e, fe, fm);
         it.b     = pick(c[2:1], r2, e, fe, fm);
         it.sw    = r2;
         sb.push_back(it);
      end else begin
         nv = m_valid && !ordy;
      end
      @(posedge clk);
      #1;
      m_valid = nv;
      m_cnt   = nc;
   endtask

   task automatic rnd_step(input logic iv, input logic fl, input logic ordy);
      step(iv, fl, ordy, CW'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
   endtask

   always @(negedge clk) begin : monitor
      item_t it;
      if (!rst) begin
         chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
         chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
         chk("stall_cnt", {48'd0, stall_cnt}, {48'd0, m_cnt});
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_nonempty", 64'd0, 64'd1);
            end else begin
               it = sb.pop_front();
               chk("ctrl_out", {37'd0, ctrl_out}, {37'd0, it.ctrl});
               chk("instr_out", {32'd0, instr_out}, {32'd0, it.instr});
               chk("alu_a", {32'd0, alu_a}, {32'd0, it.a});
               chk("alu_b", {32'd0, alu_b}, {32'd0, it.b});
               chk("sw_rt", {32'd0, sw_rt}, {32'd0, it.sw});
               chk("alu_op", {59'd0, alu_op}, {59'd0, 5'((it.ctrl >> 14) & 27'h1F)});
               chk("reg_dst", {62'd0, reg_dst}, {62'd0, 2'((it.ctrl >> 5) & 27'h3)});
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 0; flush = 0; out_ready = 0; ctrl_in = '0;
      rd1_in = '0; rd2_in = '0; ext_in = '0; fwd_exmem = '0; fwd_memwb = '0; instr_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_ctrl_out", {37'd0, ctrl_out}, 64'd0);
      chk("reset_stall_cnt", {48'd0, stall_cnt}, 64'd0);
      rst = 1'b0;

      // Load from immediate: ASEL=01 -> ctrl bit 3
      step(1, 0, 1, 27'h8, 32'h1111, 32'h2222, 32'h0000_0010, 32'h0, 32'h0, 32'hABCD_0001);
      chk("load_alu_a", {32'd0, alu_a}, 64'h10);
      chk("load_out_valid", {63'd0, out_valid}, 64'd1);

      // Three stall cycles with new data offered
      for (int i = 0; i < 3; i++) begin
         rnd_step(1, 0, 0);
         chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
         chk("stall_alu_a_hold", {32'd0, alu_a}, 64'h10);
      end
      chk("stall_cnt_3", {48'd0, stall_cnt}, 64'd3);
      step(1, 0, 1, 27'h0, 32'h5555, 32'h6666, 32'h0, 32'h0, 32'h0, 32'h0000_0002);
      chk("after_stall_load_a", {32'd0, alu_a}, 64'h5555);

      // Flush beats load on the same edge
      step(1, 1, 1, 27'h7FF_FFFF, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6);
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_ctrl_out", {37'd0, ctrl_out}, 64'd0);

      // Forward select on ALU-A
      step(1, 0, 1, 27'h10, 32'h0000_1234, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0);
      chk("fwd_alu_a", {32'd0, alu_a}, FWD ? 64'hDEAD_BEEF : 64'h1234);

      // Asynchronous reset in the middle of a stall
      step(1, 0, 0, 27'h0, 32'h77, 32'h88, 32'h0, 32'h0, 32'h0, 32'h9);
      rnd_step(1, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("async_rst_alu_a", {32'd0, alu_a}, 64'd0);
      chk("async_rst_instr", {32'd0, instr_out}, 64'd0);
      chk("async_rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
      m_valid = 1'b0; m_cnt = 16'd0; sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      rnd_step(0, 0, 1);
      chk("post_rst_no_load", {63'd0, out_valid}, 64'd0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         rnd_step(($urandom_range(3) != 0), ($urandom_range(7) == 0), ($urandom_range(2) != 0));
      end

      // Long stall to drive the counter into saturation
      rnd_step(1, 0, 1);
      for (int i = 0; i < 70000; i++) rnd_step($urandom_range(1), 0, 0);
      chk("stall_cnt_sat", {48'd0, stall_cnt}, 64'hFFFF);
      rnd_step(0, 0, 1);
      rnd_step(0, 0, 1);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/idex_pipe_reg.md
IDEX_PIPE_REG -- requirements
Module: idex_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result datapath width.
REQ-002 SHALL have parameter CTRL_W, default 27, control-stream width.
REQ-003 SHALL have parameter ASEL_LSB, default 3, LSB of 2-bit ALU-A select field in ctrl_in.
REQ-004 SHALL have parameter BSEL_LSB, default 1, LSB of 2-bit ALU-B select field in ctrl_in.
REQ-005 SHALL have parameter ALUOP_LSB, default 14, LSB of 5-bit ALU opcode field in the control stream.
REQ-006 SHALL have parameter REGDST_LSB, default 5, LSB of 2-bit register-destination field in the control stream.
REQ-007 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ports: ctrl_in  in  CTRL_W  decoded control; rd1_in, rd2_in, ext_in  in  DATA_W  register reads / extended immediate; instr_in  in  32  instruction.
REQ-009 SHALL have ports: fwd_exmem, fwd_memwb  in  DATA_W  forwarded results; in_valid  in  1; in_ready  out  1; flush  in  1  bubble request; out_ready  in  1  EX accepts.
REQ-010 SHALL have ports: alu_a, alu_b, sw_rt  out  DATA_W; instr_out  out  32; ctrl_out  out  CTRL_W; out_valid  out  1; alu_op  out  5; reg_dst  out  2; stall_cnt  out  16.

Function
REQ-011 in_ready SHALL equal !out_valid || out_ready (combinational); a load occurs on a rising clk when in_valid && in_ready && !flush.
REQ-012 On load, ctrl_out, instr_out, sw_rt (=rd2_in), alu_a, alu_b SHALL capture in the same edge; out_valid SHALL become 1; latency one cycle.
REQ-013 alu_a select = ctrl_in[ASEL_LSB+:2]: 00 rd1_in, 01 ext_in, 10 fwd_exmem, 11 fwd_memwb; alu_b select = ctrl_in[BSEL_LSB+:2]: 00 rd2_in, 01 ext_in, 10 fwd_exmem, 11 fwd_memwb; every code SHALL drive a defined value.
REQ-014 When out_valid && !out_ready && !flush, all registered outputs SHALL hold their values (stall).
REQ-015 When no load, no flush, and out_ready (or !out_valid), out_valid SHALL become 0; data registers may hold.
REQ-016 flush SHALL take priority over load and stall: next edge sets out_valid=0 and ctrl_out=0; incoming in_valid data is dropped.
REQ-017 alu_op SHALL equal ctrl_out[ALUOP_LSB+:5] and reg_dst SHALL equal ctrl_out[REGDST_LSB+:2], combinational from registered control.
REQ-018 stall_cnt SHALL increment by 1 on each edge where out_valid && !out_ready, saturate at 16'hFFFF, and never wrap.

Reset
REQ-019 rst high SHALL immediately clear out_valid, ctrl_out, instr_out, alu_a, alu_b, sw_rt, stall_cnt to 0, independent of clk.
REQ-020 Reset asserted mid-stall or mid-load SHALL discard the pending transfer; first load after release needs a fresh in_valid.

Configuration
REQ-021 Macro IDEX_FWD_EN defined: select codes 10/11 route fwd_exmem/fwd_memwb per REQ-013.
REQ-022 IDEX_FWD_EN undefined: codes 10/11 SHALL route as 00 (rd1_in / rd2_in); forwarding ports remain present and are ignored.

Structure
REQ-023 Package idex_pkg SHALL hold operand-select code constants (SEL_RD, SEL_EXT, SEL_FWD_EXMEM, SEL_FWD_MEMWB) and default width constants.
REQ-024 Sub-module idex_operand_mux (4:1, DATA_W wide) SHALL be instantiated twice, for alu_a and alu_b.

Verification
REQ-025 Reset: rst=1 with prior out_valid=1 -> all outputs 0 immediately, before next clk.
REQ-026 Load: in_valid=1, ctrl_in ASEL=01, ext_in=32'h0000_0010, out_ready=1 -> one edge later alu_a=32'h10, out_valid=1.
REQ-027 Stall: out_ready=0 for 3 cycles with out_valid=1 -> outputs held, in_ready=0, stall_cnt=3; out_ready=1 -> next input loads.
REQ-028 Flush vs load: flush=1, in_valid=1 same edge -> out_valid=0, ctrl_out=0, input dropped.
REQ-029 Forwarding: ASEL=10, fwd_exmem=32'hDEAD_BEEF -> alu_a=32'hDEAD_BEEF with IDEX_FWD_EN; alu_a=rd1_in without.
REQ-030 Saturation: preload stall_cnt near max, hold out_ready=0 70000 cycles -> stall_cnt stays 16'hFFFF.
